// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller.
//
// Produces per-stage hold (stall) and clear (flush) vectors for an in-order
// pipeline, runs timed stalls on behalf of multi-cycle units, and issues a
// PC redirect on flush. Also keeps saturating performance counters.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stallreq          level stall request, bit k-1 = stage k
//   timed_valid       one-cycle pulse launching a timed stall
//   timed_stage       stage requesting the timed stall (0 or >STAGES = none)
//   timed_cycles      timed stall length in cycles (0 = no stall)
//   flush_req         one-cycle flush/redirect request
//   flush_pc          redirect target, sampled with flush_req
//   stall             hold vector, bit 0 = PC, bit k = stage k register
//   flush             clear vector, same mapping as stall
//   new_pc_valid      redirect strobe
//   new_pc            redirect target (holds last value between strobes)
//   timed_busy        timed stall in progress
//   timed_done        pulse in the cycle after the last timed-stall cycle
//   stall_cnt         saturating count of cycles with stall[0]=1
//   flush_cnt         saturating count of flushes
module pipe_ctrl #(
    parameter int STAGES    = 5,
    parameter int CNT_W     = 4,
    parameter int FLUSH_LAT = 1,
    parameter int PERF_W    = 32,
    localparam int SW       = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              timed_valid,
    input  logic [SW-1:0]     timed_stage,
    input  logic [CNT_W-1:0]  timed_cycles,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [STAGES:0]   stall,
    output logic [STAGES:0]   flush,
    output logic              new_pc_valid,
    output logic [31:0]       new_pc,
    output logic              timed_busy,
    output logic              timed_done,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, TIMED, FLUSH_HOLD} state_t;

    localparam logic [3:0] HOLD_INIT = 4'(FLUSH_LAT);

    state_t             state;
    logic [CNT_W-1:0]   timed_cnt;
    logic [SW-1:0]      timed_stage_r;
    logic [3:0]         hold_cnt;
    logic               done_r;
    logic [31:0]        pc_r;

    logic               req_legal;
    logic               accept;
    logic [SW-1:0]      active_stage;
    logic [SW-1:0]      eff_stage;
    logic [STAGES:0]    stall_vec;

    // A timed request is only taken in RUN and only when nothing outranks it
    // this cycle; in TIMED or FLUSH_HOLD it is dropped, never queued.
    assign req_legal = timed_valid && (timed_stage != '0)
                       && (int'(timed_stage) <= STAGES) && (timed_cycles != '0);
    assign accept    = !rst && !flush_req && (state == RUN) && req_legal;

    // Effective stall stage: the deepest stage holding, from either a level
    // request or the timed stall. The timed stall already covers its
    // acceptance cycle, so the incoming stage is used directly then.
    always_comb begin
        active_stage = '0;
        if (accept)
            active_stage = timed_stage;
        else if (state == TIMED)
            active_stage = timed_stage_r;

        eff_stage = active_stage;
        for (int k = 1; k <= STAGES; k++) begin
            if (stallreq[k-1] && (SW'(k) > eff_stage))
                eff_stage = SW'(k);
        end

        stall_vec = '0;
        for (int i = 0; i <= STAGES; i++) begin
            stall_vec[i] = (eff_stage != '0) && (SW'(i) <= eff_stage);
        end
        if (state == FLUSH_HOLD)
            stall_vec[0] = 1'b1;
    end

    // Output gating: reset silences everything, a flush beats any stall.
    always_comb begin
        stall        = (rst || flush_req) ? '0 : stall_vec;
        flush        = (!rst && flush_req) ? '1 : '0;
        new_pc_valid = !rst && flush_req;
        if (rst)
            new_pc = '0;
        else if (flush_req)
            new_pc = flush_pc;
        else
            new_pc = pc_r;
        timed_busy   = !rst && !flush_req && (accept || (state == TIMED));
        timed_done   = !rst && done_r;
    end

    // Control FSM, redirect register and performance counters. done_r is
    // armed only on the natural end of a timed stall, so a flush or reset
    // that cuts one short never produces a completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            timed_cnt     <= '0;
            timed_stage_r <= '0;
            hold_cnt      <= '0;
            done_r        <= 1'b0;
            pc_r          <= '0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
        end else begin
            done_r <= 1'b0;
            if (flush_req) begin
                pc_r      <= flush_pc;
                timed_cnt <= '0;
                hold_cnt  <= HOLD_INIT;
                state     <= (FLUSH_LAT == 0) ? RUN : FLUSH_HOLD;
                if (flush_cnt != '1)
                    flush_cnt <= flush_cnt + PERF_W'(1);
            end else begin
                case (state)
                    RUN: begin
                        if (accept) begin
                            timed_stage_r <= timed_stage;
                            if (timed_cycles == CNT_W'(1)) begin
                                done_r <= 1'b1;
                            end else begin
                                state     <= TIMED;
                                timed_cnt <= timed_cycles - CNT_W'(1);
                            end
                        end
                    end
                    TIMED: begin
                        timed_cnt <= timed_cnt - CNT_W'(1);
                        if (timed_cnt == CNT_W'(1)) begin
                            state  <= RUN;
                            done_r <= 1'b1;
                        end
                    end
                    FLUSH_HOLD: begin
                        hold_cnt <= hold_cnt - 4'd1;
                        if (hold_cnt <= 4'd1)
                            state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
            if (stall[0] && (stall_cnt != '1))
                stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- scoreboard testbench for pipe_ctrl.
//
// The stimulus side drives one input set per cycle and pushes the expected
// outputs, computed by a small behavioural model, onto a queue. A monitor
// pops and compares on every falling edge. A second instance with narrow
// performance counters shares the inputs to exercise saturation.
module tb_pipe_ctrl;

    localparam int STAGES    = 5;
    localparam int FLUSH_LAT = 1;
    localparam int SAT_W     = 3;

    logic        clk;
    logic        rst;
    logic [4:0]  stallreq;
    logic        timed_valid;
    logic [2:0]  timed_stage;
    logic [3:0]  timed_cycles;
    logic        flush_req;
    logic [31:0] flush_pc;

    logic [5:0]  stall, flush;
    logic        new_pc_valid, timed_busy, timed_done;
    logic [31:0] new_pc, stall_cnt, flush_cnt;

    logic [5:0]       s_stall, s_flush;
    logic             s_npv, s_busy, s_done;
    logic [31:0]      s_npc;
    logic [SAT_W-1:0] s_scnt, s_fcnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic        npv;
        logic [31:0] npc;
        logic        busy;
        logic        done;
        longint      scnt;
        longint      fcnt;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state: cycles of timed stall still to run, the
    // stage it covers, hold cycles left, a pending completion pulse, the
    // last redirect target and unbounded event counts.
    int          m_tleft = 0;
    int          m_tstage = 0;
    int          m_hold = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_pc = '0;
    longint      m_scnt = 0;
    longint      m_fcnt = 0;

    pipe_ctrl #(.STAGES(STAGES), .CNT_W(4), .FLUSH_LAT(FLUSH_LAT), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .timed_valid(timed_valid),
        .timed_stage(timed_stage), .timed_cycles(timed_cycles),
        .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall), .flush(flush),
        .new_pc_valid(new_pc_valid), .new_pc(new_pc), .timed_busy(timed_busy),
        .timed_done(timed_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.STAGES(STAGES), .CNT_W(4), .FLUSH_LAT(FLUSH_LAT), .PERF_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .stallreq(stallreq), .timed_valid(timed_valid),
        .timed_stage(timed_stage), .timed_cycles(timed_cycles),
        .flush_req(flush_req), .flush_pc(flush_pc), .stall(s_stall), .flush(s_flush),
        .new_pc_valid(s_npv), .new_pc(s_npc), .timed_busy(s_busy),
        .timed_done(s_done), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check_output(input string name, input logic [63:0] act,
                                         input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic longint clamp(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    // Drive one cycle of inputs and record what the outputs must be.
    task automatic apply_stimulus(input logic r, input logic [4:0] sreq, input logic tv,
                                  input logic [2:0] ts, input logic [3:0] tc,
                                  input logic fr, input logic [31:0] fpc);
        exp_t e;
        int   stage_on;
        int   top;
        @(posedge clk);
        #1;
        rst = r; stallreq = sreq; timed_valid = tv; timed_stage = ts;
        timed_cycles = tc; flush_req = fr; flush_pc = fpc;

        e.stall = '0; e.flush = '0; e.npv = 1'b0; e.busy = 1'b0;
        e.npc = m_pc; e.done = m_done; e.scnt = m_scnt; e.fcnt = m_fcnt;

        if (r) begin
            e.npc = '0; e.done = 1'b0;
            m_tleft = 0; m_hold = 0; m_done = 1'b0; m_pc = '0;
            m_scnt = 0; m_fcnt = 0;
        end else if (fr) begin
            e.flush = '1; e.npv = 1'b1; e.npc = fpc;
            m_pc = fpc; m_tleft = 0; m_hold = FLUSH_LAT; m_done = 1'b0;
            m_fcnt++;
        end else begin
            stage_on = 0;
            if (m_tleft == 0 && m_hold == 0 && tv && ts >= 1 && ts <= STAGES && tc != 0) begin
                m_tleft  = int'(tc);
                m_tstage = int'(ts);
            end
            if (m_tleft > 0) begin
                stage_on = m_tstage;
                e.busy   = 1'b1;
                m_tleft--;
                m_done   = (m_tleft == 0);
            end else begin
                m_done = 1'b0;
            end
            top = stage_on;
            for (int k = 1; k <= STAGES; k++)
                if (sreq[k-1] && k > top) top = k;
            for (int i = 0; i <= STAGES; i++)
                e.stall[i] = (top > 0) && (i <= top);
            if (m_hold > 0) begin
                e.stall[0] = 1'b1;
                m_hold--;
            end
            if (e.stall[0]) m_scnt++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 5'b0, 1'b0, 3'd0, 4'd0, 1'b0, 32'h0);
    endtask

    task automatic timed(input logic [2:0] ts, input logic [3:0] tc, input logic [4:0] sreq);
        apply_stimulus(1'b0, sreq, 1'b1, ts, tc, 1'b0, 32'h0);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        apply_stimulus(1'b0, 5'b0, 1'b0, 3'd0, 4'd0, 1'b1, pc);
    endtask

    // Monitor: compare every presented output cycle against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("stall", 64'(stall), 64'(e.stall));
            check_output("flush", 64'(flush), 64'(e.flush));
            check_output("new_pc_valid", 64'(new_pc_valid), 64'(e.npv));
            check_output("new_pc", 64'(new_pc), 64'(e.npc));
            check_output("timed_busy", 64'(timed_busy), 64'(e.busy));
            check_output("timed_done", 64'(timed_done), 64'(e.done));
            check_output("stall_cnt", 64'(stall_cnt), 64'(clamp(e.scnt, 64'hFFFF_FFFF)));
            check_output("flush_cnt", 64'(flush_cnt), 64'(clamp(e.fcnt, 64'hFFFF_FFFF)));
            check_output("sat_stall_cnt", 64'(s_scnt), 64'(clamp(e.scnt, (1 << SAT_W) - 1)));
            check_output("sat_flush_cnt", 64'(s_fcnt), 64'(clamp(e.fcnt, (1 << SAT_W) - 1)));
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; stallreq = '0; timed_valid = 1'b0; timed_stage = '0;
        timed_cycles = '0; flush_req = 1'b0; flush_pc = '0;

        apply_stimulus(1'b1, 5'b0, 1'b0, 3'd0, 4'd0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 5'b11111, 1'b1, 3'd2, 4'd3, 1'b1, 32'hDEAD_BEEF);
        idle(2);

        // Level stall on stage 2 held for three cycles.
        repeat (3) apply_stimulus(1'b0, 5'b00010, 1'b0, 3'd0, 4'd0, 1'b0, 32'h0);
        idle(1);

        // Timed stall stage 3, N=4, with a second request in cycle 2.
        timed(3'd3, 4'd4, 5'b0);
        timed(3'd5, 4'd2, 5'b0);
        idle(5);

        // Timed stall stage 3 overlapped by a level request from stage 4.
        timed(3'd3, 4'd5, 5'b0);
        repeat (2) apply_stimulus(1'b0, 5'b01000, 1'b0, 3'd0, 4'd0, 1'b0, 32'h0);
        idle(4);

        // Flush in cycle 2 of a timed stall.
        timed(3'd3, 4'd4, 5'b0);
        do_flush(32'hBFC0_0380);
        idle(4);

        // Back-to-back flushes, then a timed request during the hold.
        do_flush(32'h0000_0100);
        do_flush(32'h0000_0200);
        timed(3'd2, 4'd3, 5'b0);
        idle(3);

        // Reset with three timed cycles remaining.
        timed(3'd3, 4'd5, 5'b0);
        idle(1);
        apply_stimulus(1'b1, 5'b00100, 1'b0, 3'd0, 4'd0, 1'b0, 32'h0);
        idle(6);

        // N=1, illegal stages and N=0.
        timed(3'd4, 4'd1, 5'b0);
        idle(2);
        timed(3'd0, 4'd3, 5'b0);
        timed(3'd6, 4'd3, 5'b0);
        timed(3'd7, 4'd3, 5'b0);
        timed(3'd5, 4'd0, 5'b0);
        idle(2);

        // Drive the narrow counters past saturation.
        for (int i = 0; i < 10; i++) do_flush(32'h1000 + 32'(i));
        repeat (12) apply_stimulus(1'b0, 5'b10000, 1'b0, 3'd0, 4'd0, 1'b0, 32'h0);
        idle(2);

        for (int i = 0; i < 2000; i++) begin
            apply_stimulus($urandom_range(0, 99) == 0,
                           5'($urandom) & 5'($urandom) & 5'($urandom),
                           $urandom_range(0, 3) == 0,
                           3'($urandom), 4'($urandom),
                           $urandom_range(0, 24) == 0, $urandom);
        end
        idle(2);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 5: number of pipeline stages (IF..WB); stage k in 1..STAGES.
REQ-002 Parameter CNT_W, default 4: width of the timed-stall cycle count.
REQ-003 Parameter FLUSH_LAT, default 1: post-flush PC-hold cycles; legal range 0..15.
REQ-004 Parameter PERF_W, default 32: width of the performance counters.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 stallreq  in  STAGES  level stall request; bit k-1 = stage k.
REQ-008 timed_valid  in  1  one-cycle pulse launching a timed stall (multi-cycle unit).
REQ-009 timed_stage  in  clog2(STAGES+1)  requesting stage k; 0 or >STAGES is treated as no request.
REQ-010 timed_cycles  in  CNT_W  stall length N in cycles; N=0 means no stall.
REQ-011 flush_req  in  1  one-cycle pulse requesting a pipeline flush and redirect.
REQ-012 flush_pc  in  32  redirect target; sampled with flush_req.
REQ-013 stall  out  STAGES+1  hold vector; bit 0 = PC, bit k = stage k register.
REQ-014 flush  out  STAGES+1  clear vector, same bit mapping as stall.
REQ-015 new_pc_valid  out  1  redirect strobe.
REQ-016 new_pc  out  32  redirect target.
REQ-017 timed_busy  out  1  timed stall in progress.
REQ-018 timed_done  out  1  one-cycle pulse in the cycle after the last timed-stall cycle.
REQ-019 stall_cnt, flush_cnt  out  PERF_W each  saturating counts of stalled cycles and flushes.

Function
REQ-020 Effective stall stage E = the highest k with stallreq[k-1]=1 or with a timed stall active for stage k; stall[E:0]=1 and all higher bits 0; E=0 gives stall=0. stall is combinational, with zero latency from stallreq.
REQ-021 FSM states RUN, TIMED, FLUSH_HOLD.
REQ-022 RUN: a timed_valid with a legal stage and N>=1 is accepted. The stall for that stage is active in the acceptance cycle and in the N-1 following cycles.
REQ-023 On acceptance with N=1: stay in RUN and pulse timed_done in the next cycle. With N>=2: go to TIMED and load the down-counter with N-1.
REQ-024 TIMED: timed_busy=1 and the stall stays active. The counter decrements each cycle; on the cycle it reaches 0 the state returns to RUN and timed_done pulses in the following cycle.
REQ-025 A timed_valid in TIMED, or in the acceptance cycle, is ignored: no queueing and no restart.
REQ-026 timed_busy=1 from the acceptance cycle through the last stall cycle.
REQ-027 flush_req in any state takes priority over everything in that cycle: flush=all ones, stall=all zeros, new_pc_valid=1, new_pc=flush_pc.
REQ-028 A flush aborts any active timed stall without a timed_done pulse and increments flush_cnt.
REQ-029 After a flush with FLUSH_LAT>0, the state is FLUSH_HOLD for FLUSH_LAT cycles, holding stall[0]=1 only. stallreq can raise stall further per REQ-020, and timed_valid is ignored. The state then returns to RUN.
REQ-030 A flush_req during FLUSH_HOLD restarts the flush: new outputs, and the hold count reloads.
REQ-031 With FLUSH_LAT=0 the state returns directly to RUN after the flush cycle.
REQ-032 new_pc holds its last value while new_pc_valid=0; flush=0 outside flush cycles.
REQ-033 stall_cnt increments in every non-reset cycle with stall[0]=1; both counters saturate at all ones and never wrap.

Reset
REQ-034 While rst=1: stall=0, flush=0, new_pc_valid=0, timed_busy=0 and timed_done=0, overriding all inputs.
REQ-035 On reset: new_pc=0, stall_cnt=0, flush_cnt=0, state=RUN and the timed counter is cleared.
REQ-036 Reset asserted mid-timed-stall or mid-hold aborts the operation with no timed_done pulse; the first cycle after reset is RUN.

Verification
REQ-037 stallreq=5'b00010 (stage 2), no other activity -> stall=6'b000111 the same cycle; stall_cnt +1 per cycle held.
REQ-038 timed_valid, stage 3, N=4, no stallreq -> stall=6'b001111 for exactly 4 cycles; timed_busy for the same 4 cycles; timed_done in cycle 5; second timed_valid in cycle 2 ignored.
REQ-039 Timed stage 3 active plus stallreq stage 4 -> stall=6'b011111; when stallreq drops the stall returns to 6'b001111.
REQ-040 flush_req with flush_pc=0xBFC00380 in cycle 2 of a timed stall (FLUSH_LAT=1) -> that cycle: flush=6'b111111, stall=0, new_pc_valid=1, new_pc=0xBFC00380. Next cycle: stall=6'b000001. No timed_done; flush_cnt=1.
REQ-041 Back-to-back flush_req in two consecutive cycles -> two strobes with the second flush_pc; the hold restarts; flush_cnt=2.
REQ-042 rst asserted during TIMED with 3 cycles remaining -> outputs zero in the reset cycle; no timed_done afterwards; counters 0.
